// File: rtl/lane_overlay_renderer_if.sv
// ---------------------------------------------------------------------------
// lane_overlay_renderer_if
// Bus bundle for lane_overlay_renderer.
//   Coefficient path : coef_wr, coef_sel, coef_m, coef_b, coef_en, frame_start
//   Pixel input      : pix_valid, x_coord, y_coord
//   Result output    : hit_valid, hit_mask, any_hit, hit_idx, out_x, out_y
// master = video/CPU side driving coefficients and pixels,
// slave  = the renderer.
// ---------------------------------------------------------------------------
interface lane_overlay_renderer_if #(
   parameter int NUM_LINES = 4,
   parameter int COORD_W   = 16,
   parameter int COEF_W    = 16
);
   localparam int IDX_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

   logic                 coef_wr;
   logic [IDX_W-1:0]     coef_sel;
   logic [COEF_W-1:0]    coef_m;
   logic [COEF_W-1:0]    coef_b;
   logic                 coef_en;
   logic                 frame_start;
   logic                 pix_valid;
   logic [COORD_W-1:0]   x_coord;
   logic [COORD_W-1:0]   y_coord;
   logic                 hit_valid;
   logic [NUM_LINES-1:0] hit_mask;
   logic                 any_hit;
   logic [IDX_W-1:0]     hit_idx;
   logic [COORD_W-1:0]   out_x;
   logic [COORD_W-1:0]   out_y;

   modport master (
      output coef_wr, coef_sel, coef_m, coef_b, coef_en, frame_start,
      output pix_valid, x_coord, y_coord,
      input  hit_valid, hit_mask, any_hit, hit_idx, out_x, out_y
   );

   modport slave (
      input  coef_wr, coef_sel, coef_m, coef_b, coef_en, frame_start,
      input  pix_valid, x_coord, y_coord,
      output hit_valid, hit_mask, any_hit, hit_idx, out_x, out_y
   );
endinterface

// File: rtl/lane_overlay_renderer.sv
// ---------------------------------------------------------------------------
// lane_overlay_renderer
// Tests each streamed pixel against NUM_LINES line equations y = m*x + b in a
// 3-stage pipeline and reports per-line hits plus a priority lane index.
// Coefficients go to a shadow bank and are committed to the active bank on
// frame_start, so a frame never sees a half-updated set of lanes.
//
// Ports:
//   CLK100MHZ  : system clock
//   CPU_RESETN : asynchronous active-low reset
//   bus        : lane_overlay_renderer_if.slave (coefficients, pixels, results)
//
// Optional macro LANE_CLIP_Y_EN: when defined, hits are suppressed for rows
// above CLIP_Y_TOP (y_coord < CLIP_Y_TOP). When undefined CLIP_Y_TOP is unused.
// ---------------------------------------------------------------------------
module lane_overlay_renderer #(
   parameter int NUM_LINES  = 4,
   parameter int COORD_W    = 16,
   parameter int COEF_W     = 16,
   parameter int FRAC_BITS  = 8,
   parameter int LINE_WIDTH = 2,
   parameter int CLIP_Y_TOP = 0
) (
   input  logic                   CLK100MHZ,
   input  logic                   CPU_RESETN,
   lane_overlay_renderer_if.slave bus
);
   localparam int IDX_W  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
   localparam int PROD_W = COEF_W + COORD_W + 1;
   localparam int BSH_W  = COEF_W + FRAC_BITS;
   // One guard bit over the wider of product and shifted intercept.
   localparam int SUM_W  = ((PROD_W > BSH_W) ? PROD_W : BSH_W) + 1;
   localparam int D_W    = SUM_W + 1;

   localparam logic signed [D_W-1:0] LW_POS = D_W'(LINE_WIDTH);
   localparam logic signed [D_W-1:0] LW_NEG = -LW_POS;

   // Shared pipeline state
   logic               s1_valid_q, s2_valid_q;
   logic [COORD_W-1:0] s1_x_q, s1_y_q, s2_x_q, s2_y_q;
   logic [NUM_LINES-1:0] hit_c;
   logic [IDX_W-1:0]     idx_c;

`ifdef LANE_CLIP_Y_EN
   logic s1_clip_ok_q, s2_clip_ok_q;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NUM_LINES; gi++) begin : gen_line
         localparam logic [IDX_W-1:0] SEL = IDX_W'(gi);

         logic signed [COEF_W-1:0] shadow_m_q, shadow_b_q, active_m_q, active_b_q;
         logic                     shadow_en_q, active_en_q;
         logic signed [COEF_W-1:0] eff_m, eff_b;
         logic                     eff_en;
         logic signed [PROD_W-1:0] s1_p_q;
         logic signed [COEF_W-1:0] s1_b_q;
         logic                     s1_en_q;
         logic signed [SUM_W-1:0]  p_ext, b_ext, sum_c, yhat_c;
         logic signed [D_W-1:0]    d_c, s2_d_q;
         logic                     s2_en_q;

         // Coefficient banks. A write in the same cycle as frame_start only
         // reaches the shadow; the commit copies the pre-write shadow.
         always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
            if (!CPU_RESETN) begin
               shadow_m_q  <= '0;
               shadow_b_q  <= '0;
               shadow_en_q <= 1'b0;
               active_m_q  <= '0;
               active_b_q  <= '0;
               active_en_q <= 1'b0;
            end else begin
               if (bus.coef_wr && (bus.coef_sel == SEL)) begin
                  shadow_m_q  <= bus.coef_m;
                  shadow_b_q  <= bus.coef_b;
                  shadow_en_q <= bus.coef_en;
               end
               if (bus.frame_start) begin
                  active_m_q  <= shadow_m_q;
                  active_b_q  <= shadow_b_q;
                  active_en_q <= shadow_en_q;
               end
            end
         end

         // A pixel arriving with frame_start already uses the committed set.
         assign eff_m  = bus.frame_start ? shadow_m_q  : active_m_q;
         assign eff_b  = bus.frame_start ? shadow_b_q  : active_b_q;
         assign eff_en = bus.frame_start ? shadow_en_q : active_en_q;

         // S2 arithmetic: floor(m*x/2^F) + b, then distance to y.
         always_comb begin
            p_ext  = SUM_W'(s1_p_q);
            b_ext  = SUM_W'(s1_b_q);
            sum_c  = p_ext + (b_ext <<< FRAC_BITS);
            yhat_c = sum_c >>> FRAC_BITS;
            d_c    = D_W'(yhat_c) - $signed(D_W'(s1_y_q));
         end

         always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
            if (!CPU_RESETN) begin
               s1_p_q  <= '0;
               s1_b_q  <= '0;
               s1_en_q <= 1'b0;
               s2_d_q  <= '0;
               s2_en_q <= 1'b0;
            end else begin
               s1_p_q  <= eff_m * $signed({1'b0, bus.x_coord});
               s1_b_q  <= eff_b;
               s1_en_q <= eff_en;
               s2_d_q  <= d_c;
               s2_en_q <= s1_en_q;
            end
         end

`ifdef LANE_CLIP_Y_EN
         assign hit_c[gi] = s2_en_q && s2_clip_ok_q && (s2_d_q >= LW_NEG) && (s2_d_q <= LW_POS);
`else
         assign hit_c[gi] = s2_en_q && (s2_d_q >= LW_NEG) && (s2_d_q <= LW_POS);
`endif
      end
   endgenerate

   // Lowest index wins.
   always_comb begin
      idx_c = '0;
      for (int i = NUM_LINES - 1; i >= 0; i--) begin
         if (hit_c[i]) idx_c = IDX_W'(i);
      end
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         s1_valid_q    <= 1'b0;
         s2_valid_q    <= 1'b0;
         s1_x_q        <= '0;
         s1_y_q        <= '0;
         s2_x_q        <= '0;
         s2_y_q        <= '0;
         bus.hit_valid <= 1'b0;
         bus.hit_mask  <= '0;
         bus.any_hit   <= 1'b0;
         bus.hit_idx   <= '0;
         bus.out_x     <= '0;
         bus.out_y     <= '0;
      end else begin
         s1_valid_q    <= bus.pix_valid;
         s1_x_q        <= bus.x_coord;
         s1_y_q        <= bus.y_coord;
         s2_valid_q    <= s1_valid_q;
         s2_x_q        <= s1_x_q;
         s2_y_q        <= s1_y_q;
         bus.hit_valid <= s2_valid_q;
         bus.hit_mask  <= s2_valid_q ? hit_c : '0;
         bus.any_hit   <= s2_valid_q && (|hit_c);
         bus.hit_idx   <= s2_valid_q ? idx_c : '0;
         // Coordinates hold their last valid value between pixels.
         if (s2_valid_q) begin
            bus.out_x <= s2_x_q;
            bus.out_y <= s2_y_q;
         end
      end
   end

`ifdef LANE_CLIP_Y_EN
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         s1_clip_ok_q <= 1'b0;
         s2_clip_ok_q <= 1'b0;
      end else begin
         s1_clip_ok_q <= (32'(bus.y_coord) >= CLIP_Y_TOP);
         s2_clip_ok_q <= s1_clip_ok_q;
      end
   end
`endif
endmodule

// File: tb/tb_lane_overlay_renderer.sv
// ---------------------------------------------------------------------------
// tb_lane_overlay_renderer
// Directed vectors against lane_overlay_renderer with hand-computed hit masks.
// Default configuration: NUM_LINES=4, COORD_W=16, COEF_W=16, FRAC_BITS=8,
// LINE_WIDTH=2. With LANE_CLIP_Y_EN the clip row is 240.
// ---------------------------------------------------------------------------
module tb_lane_overlay_renderer;
`ifdef LANE_CLIP_Y_EN
   localparam int CLIP = 240;
`else
   localparam int CLIP = 0;
`endif

   logic clk;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;

   lane_overlay_renderer_if #(.NUM_LINES(4), .COORD_W(16), .COEF_W(16)) bus ();

   lane_overlay_renderer #(
      .NUM_LINES(4), .COORD_W(16), .COEF_W(16), .FRAC_BITS(8),
      .LINE_WIDTH(2), .CLIP_Y_TOP(CLIP)
   ) dut (
      .CLK100MHZ (clk),
      .CPU_RESETN(rst_n),
      .bus       (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic write_coef(input logic [1:0] sel, input logic signed [15:0] m,
                             input logic signed [15:0] b, input logic en, input logic commit);
      @(negedge clk);
      bus.coef_wr     = 1'b1;
      bus.coef_sel    = sel;
      bus.coef_m      = m;
      bus.coef_b      = b;
      bus.coef_en     = en;
      bus.frame_start = commit;
      @(negedge clk);
      bus.coef_wr     = 1'b0;
      bus.frame_start = 1'b0;
   endtask

   task automatic commit_bank();
      @(negedge clk);
      bus.frame_start = 1'b1;
      @(negedge clk);
      bus.frame_start = 1'b0;
   endtask

   // Presents one pixel and checks the result exactly 3 cycles later.
   task automatic send_pixel(input string tag, input logic [15:0] x, input logic [15:0] y,
                             input logic [3:0] mask, input logic [1:0] idx, input logic commit);
      logic [3:0] exp_mask;
      logic [1:0] exp_idx;
      exp_mask = mask;
      exp_idx  = idx;
      if (32'(y) < CLIP) begin
         exp_mask = 4'b0;
         exp_idx  = 2'd0;
      end
      @(negedge clk);
      bus.pix_valid   = 1'b1;
      bus.x_coord     = x;
      bus.y_coord     = y;
      bus.frame_start = commit;
      @(negedge clk);
      bus.pix_valid   = 1'b0;
      bus.frame_start = 1'b0;
      @(posedge clk);
      #1;
      check_value({tag, "_early"}, 64'(bus.hit_valid), 64'd0);
      @(posedge clk);
      #1;
      check_value({tag, "_valid"}, 64'(bus.hit_valid), 64'd1);
      check_value({tag, "_mask"}, 64'(bus.hit_mask), 64'(exp_mask));
      check_value({tag, "_any"}, 64'(bus.any_hit), 64'(exp_mask != 4'b0));
      check_value({tag, "_idx"}, 64'(bus.hit_idx), 64'(exp_idx));
      check_value({tag, "_x"}, 64'(bus.out_x), 64'(x));
      check_value({tag, "_y"}, 64'(bus.out_y), 64'(y));
      $display("pixel %s x=%0d y=%0d mask=%b idx=%0d", tag, x, y, bus.hit_mask, bus.hit_idx);
   endtask

   initial begin
      rst_n           = 1'b0;
      bus.coef_wr     = 1'b0;
      bus.coef_sel    = '0;
      bus.coef_m      = '0;
      bus.coef_b      = '0;
      bus.coef_en     = 1'b0;
      bus.frame_start = 1'b0;
      bus.pix_valid   = 1'b0;
      bus.x_coord     = '0;
      bus.y_coord     = '0;

      #1;
      check_value("rst_valid", 64'(bus.hit_valid), 64'd0);
      check_value("rst_mask", 64'(bus.hit_mask), 64'd0);
      check_value("rst_idx", 64'(bus.hit_idx), 64'd0);
      check_value("rst_out_x", 64'(bus.out_x), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Line 0: y = x + 10
      write_coef(2'd0, 16'sd256, 16'sd10, 1'b1, 1'b0);
      commit_bank();
      send_pixel("l0_y32", 16'd20, 16'd32, 4'b0001, 2'd0, 1'b0);
      send_pixel("l0_y33", 16'd20, 16'd33, 4'b0000, 2'd0, 1'b0);
      send_pixel("l0_y28", 16'd20, 16'd28, 4'b0001, 2'd0, 1'b0);

      // Line 1: y = -0.5x + 100
      write_coef(2'd1, -16'sd128, 16'sd100, 1'b1, 1'b0);
      commit_bank();
      send_pixel("l1_y77", 16'd50, 16'd77, 4'b0010, 2'd1, 1'b0);
      send_pixel("l1_y78", 16'd50, 16'd78, 4'b0000, 2'd0, 1'b0);

      // Line 1 with b=0: floor(-1.5) = -2
      write_coef(2'd1, -16'sd128, 16'sd0, 1'b1, 1'b0);
      commit_bank();
      send_pixel("floor_y0", 16'd3, 16'd0, 4'b0010, 2'd1, 1'b0);
      send_pixel("floor_y1", 16'd3, 16'd1, 4'b0000, 2'd0, 1'b0);

      // Line 2: y = -x, negative y_hat must not wrap into a hit
      write_coef(2'd2, -16'sd256, 16'sd0, 1'b1, 1'b0);
      commit_bank();
      send_pixel("neg_wrap", 16'd10, 16'd0, 4'b0000, 2'd0, 1'b0);
      send_pixel("l2_x0", 16'd0, 16'd2, 4'b0110, 2'd1, 1'b0);

      // Line 3: y = 30, overlaps line 0 at (20,30)
      write_coef(2'd3, 16'sd0, 16'sd30, 1'b1, 1'b0);
      commit_bank();
      send_pixel("prio", 16'd20, 16'd30, 4'b1001, 2'd0, 1'b0);
      write_coef(2'd0, 16'sd256, 16'sd10, 1'b0, 1'b0);
      commit_bank();
      send_pixel("l0_off", 16'd20, 16'd30, 4'b1000, 2'd3, 1'b0);

      // Shadow isolation
      write_coef(2'd0, 16'sd256, 16'sd50, 1'b1, 1'b0);
      send_pixel("shadow_a", 16'd20, 16'd30, 4'b1000, 2'd3, 1'b0);
      send_pixel("shadow_b", 16'd20, 16'd70, 4'b0000, 2'd0, 1'b0);
      write_coef(2'd0, 16'sd256, 16'sd10, 1'b0, 1'b0);
      write_coef(2'd0, 16'sd256, 16'sd50, 1'b1, 1'b1);  // write + commit together
      send_pixel("wrcm_old70", 16'd20, 16'd70, 4'b0000, 2'd0, 1'b0);
      send_pixel("wrcm_old30", 16'd20, 16'd30, 4'b1000, 2'd3, 1'b0);
      commit_bank();
      send_pixel("wrcm_new70", 16'd20, 16'd70, 4'b0001, 2'd0, 1'b0);
      send_pixel("wrcm_new30", 16'd20, 16'd30, 4'b1000, 2'd3, 1'b0);

      // Pixel on the commit cycle sees the new coefficients
      write_coef(2'd0, 16'sd0, 16'sd5, 1'b1, 1'b0);
      send_pixel("same_cyc", 16'd7, 16'd5, 4'b0001, 2'd0, 1'b1);

      // Horizontal line at y=240 around the clip row
      write_coef(2'd3, 16'sd0, 16'sd240, 1'b1, 1'b0);
      commit_bank();
      send_pixel("clip_239", 16'd0, 16'd239, 4'b1000, 2'd3, 1'b0);
      send_pixel("clip_240", 16'd0, 16'd240, 4'b1000, 2'd3, 1'b0);

      // Reset while a result is on the outputs
      @(negedge clk);
      bus.pix_valid = 1'b1;
      bus.x_coord   = 16'd5;
      bus.y_coord   = 16'd6;
      @(negedge clk);
      bus.pix_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check_value("pre_rst_valid", 64'(bus.hit_valid), 64'd1);
      check_value("pre_rst_mask", 64'(bus.hit_mask), (CLIP <= 6) ? 64'd1 : 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check_value("async_rst_valid", 64'(bus.hit_valid), 64'd0);
      check_value("async_rst_mask", 64'(bus.hit_mask), 64'd0);
      check_value("async_rst_out_x", 64'(bus.out_x), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_value("post_rst_idle", 64'(bus.hit_valid), 64'd0);
      end
      // Banks were cleared: nothing hits, even after a commit.
      send_pixel("post_rst", 16'd20, 16'd30, 4'b0000, 2'd0, 1'b0);
      commit_bank();
      send_pixel("post_rst_cm", 16'd5, 16'd6, 4'b0000, 2'd0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
